// File: rtl/test_status_reporter.sv
// Test-status reporter: drives start/pass/fail/timeout codes and a pc word to GPIO.
// Watchdog timeout state is present only when TEST_STATUS_TIMEOUT_EN is defined.
module test_status_reporter #(
   parameter int              CODE_W         = 6,
   parameter int              DATA_W         = 32,
   parameter int              NUM_CH         = 4,
   parameter logic [CODE_W-1:0] CODE_IDLE    = 'h00,
   parameter logic [CODE_W-1:0] CODE_RUN     = 'h18,
   parameter logic [CODE_W-1:0] CODE_PASS    = 'h19,
   parameter logic [CODE_W-1:0] CODE_FAIL    = 'h1a,
   parameter logic [CODE_W-1:0] CODE_TIMEOUT = 'h1b,
   parameter int              TIMEOUT_CYCLES = 90000,
   parameter int              CNT_W          = 16,
   localparam int             FW             = $clog2(NUM_CH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              done,
   input  logic [DATA_W-1:0] pc,
   input  logic [NUM_CH-1:0] assert_valid,
   input  logic [NUM_CH-1:0] assert_ok,
   output logic [CODE_W-1:0] status_code,
   output logic [DATA_W-1:0] status_data,
   output logic [FW-1:0]     fail_ch,
   output logic [CNT_W-1:0]  check_count,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   localparam int SUM_W = CNT_W + 5;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state, state_n;
   logic [CODE_W-1:0] code_n;
   logic [NUM_CH-1:0] bad, good;
   logic [FW-1:0] bad_idx;
   logic [4:0] pop;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_sat;
   logic wd_hit;
   logic in_run;

   assign in_run = (state == S_RUN);
   assign bad  = assert_valid & ~assert_ok;
   assign good = assert_valid & assert_ok;

   // Scan high to low so the lowest failing channel wins
   always_comb begin
      bad_idx = '1;
      pop = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (bad[i]) bad_idx = FW'(i);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         pop = pop + {4'b0, good[i]};
      end
   end

   assign sum = SUM_W'(check_count) + SUM_W'(pop);
   assign cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

`ifdef TEST_STATUS_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WD_W-1:0] wd;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd <= '0;
      end else if (in_run) begin
         wd <= wd + 1'b1;
      end else begin
         wd <= '0;
      end
   end

   assign wd_hit = (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      code_n  = CODE_IDLE;
      unique case (state)
         S_RUN: begin
            if (|bad)        state_n = S_FAIL;
            else if (done)   state_n = S_PASS;
            else if (wd_hit) state_n = S_TIMEOUT;
         end
         default: begin
            if (start) state_n = S_RUN;
         end
      endcase
      unique case (state_n)
         S_RUN:     code_n = CODE_RUN;
         S_PASS:    code_n = CODE_PASS;
         S_FAIL:    code_n = CODE_FAIL;
         S_TIMEOUT: code_n = CODE_TIMEOUT;
         default:   code_n = CODE_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status_code <= CODE_IDLE;
         status_data <= '0;
         fail_ch     <= '1;
         check_count <= '0;
         busy        <= 1'b0;
      end else begin
         status_code <= code_n;
         busy        <= (state_n == S_RUN);
         if (in_run) status_data <= pc;
         if (!in_run && start) begin
            fail_ch     <= '1;
            check_count <= '0;
         end else if (in_run) begin
            if (|bad) fail_ch     <= bad_idx;
            else      check_count <= cnt_sat;
         end
      end
   end

endmodule
